// File: rtl/fpna_cfg_scheduler.sv
// fpna_cfg_scheduler
// Byte-stream command decoder that configures and sequences an FPNA neuron
// array. A header byte in IDLE selects NOP, LOAD (write CFG_BYTES bytes into
// one cell) or RUN (sweep a step strobe across every cell 1..64 times).
// All strobes and address/data outputs are registered; step and cfg_ready
// follow directly from the state register.
module fpna_cfg_scheduler #(
  parameter int NCELLS    = 8,
  parameter int CFG_BYTES = 4,
  localparam int CW = $clog2(NCELLS),
  localparam int AW = (CFG_BYTES > 1) ? $clog2(CFG_BYTES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    cfg_data,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  output logic [CW-1:0] cell_sel,
  output logic [AW-1:0] cfg_addr,
  output logic [7:0]    cfg_wdata,
  output logic          cfg_we,
  output logic          step,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_RUN  = 2'b10,
    OP_ILL  = 2'b11
  } opcode_t;

  localparam logic [AW-1:0] LAST_IDX  = AW'(CFG_BYTES - 1);
  localparam logic [CW-1:0] LAST_CELL = CW'(NCELLS - 1);

  state_t        state_q,     state_d;
  logic [CW-1:0] cell_q,      cell_d;       // cell latched by a LOAD header
  logic [AW-1:0] idx_q,       idx_d;        // next byte index within the cell
  logic [5:0]    sweeps_m1_q, sweeps_m1_d;  // requested sweeps minus one
  logic [5:0]    sweep_cnt_q, sweep_cnt_d;  // sweeps completed in this RUN
  logic [CW-1:0] cell_sel_q,  cell_sel_d;
  logic [AW-1:0] cfg_addr_q,  cfg_addr_d;
  logic [7:0]    cfg_wdata_q, cfg_wdata_d;
  logic          cfg_we_q,    cfg_we_d;
  logic          done_q,      done_d;
  logic          err_q,       err_d;

  logic    accept;
  opcode_t opcode;

  assign cfg_ready = (state_q != ST_RUN);
  assign accept    = cfg_valid & cfg_ready;
  assign opcode    = opcode_t'(cfg_data[7:6]);

  // Next-state and next-output logic for the IDLE/LOAD/RUN sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cell_d      = cell_q;
    idx_d       = idx_q;
    sweeps_m1_d = sweeps_m1_q;
    sweep_cnt_d = sweep_cnt_q;
    cell_sel_d  = cell_sel_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_wdata_d = cfg_wdata_q;
    cfg_we_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (opcode)
            OP_LOAD: begin
              cell_d  = cfg_data[CW-1:0];
              idx_d   = '0;
              state_d = ST_LOAD;
            end
            OP_RUN: begin
              sweeps_m1_d = cfg_data[5:0];
              sweep_cnt_d = '0;
              // First step is driven on the very next cycle, so cell 0 is
              // selected at the same edge that enters RUN.
              cell_sel_d  = '0;
              state_d     = ST_RUN;
            end
            OP_ILL:  err_d = 1'b1;
            default: ;  // NOP: nothing happens
          endcase
        end
      end

      ST_LOAD: begin
        if (accept) begin
          cfg_we_d    = 1'b1;
          cfg_wdata_d = cfg_data;
          cfg_addr_d  = idx_q;
          cell_sel_d  = cell_q;
          if (idx_q == LAST_IDX) begin
            // Back to IDLE now so a header can be taken during the trailing
            // write cycle.
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (cell_sel_q == LAST_CELL) begin
          if (sweep_cnt_q == sweeps_m1_q) begin
            // Last step of the last sweep: cell_sel holds its final value.
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            sweep_cnt_d = sweep_cnt_q + 1'b1;
            cell_sel_d  = '0;
          end
        end else begin
          cell_sel_d = cell_sel_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset that beats any transfer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    if (rst) begin
      state_q     <= ST_IDLE;
      cell_q      <= '0;
      idx_q       <= '0;
      sweeps_m1_q <= '0;
      sweep_cnt_q <= '0;
      cell_sel_q  <= '0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
      cfg_we_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cell_q      <= cell_d;
      idx_q       <= idx_d;
      sweeps_m1_q <= sweeps_m1_d;
      sweep_cnt_q <= sweep_cnt_d;
      cell_sel_q  <= cell_sel_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
      cfg_we_q    <= cfg_we_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign step      = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE) | cfg_we_q;
  assign cell_sel  = cell_sel_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_wdata = cfg_wdata_q;
  assign cfg_we    = cfg_we_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fpna_cfg_scheduler.sv
// Directed testbench for fpna_cfg_scheduler (NCELLS=8, CFG_BYTES=4).
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point, i.e. they show the result of the edge just taken.
module tb_fpna_cfg_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cell_sel;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       cfg_we;
  logic       step;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  // Activity monitor counters, updated once per cycle by cyc().
  int step_cnt = 0;
  int done_cnt = 0;
  int we_cnt   = 0;
  int both_cnt = 0;

  fpna_cfg_scheduler #(.NCELLS(8), .CFG_BYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cell_sel  (cell_sel),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_we    (cfg_we),
    .step      (step),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then tally the strobes visible after it.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (step)          step_cnt++;
    if (done)          done_cnt++;
    if (cfg_we)        we_cnt++;
    if (cfg_we & step) both_cnt++;
  endtask

  task automatic clear_counts();
    step_cnt = 0;
    done_cnt = 0;
    we_cnt   = 0;
    both_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ready"},    32'(cfg_ready), 32'd1);
    check({tag, ".we"},       32'(cfg_we),    32'd0);
    check({tag, ".step"},     32'(step),      32'd0);
    check({tag, ".done"},     32'(done),      32'd0);
    check({tag, ".busy"},     32'(busy),      32'd0);
    check({tag, ".err"},      32'(err),       32'd0);
    check({tag, ".cell_sel"}, 32'(cell_sel),  32'd0);
    check({tag, ".addr"},     32'(cfg_addr),  32'd0);
    check({tag, ".wdata"},    32'(cfg_wdata), 32'd0);
  endtask

  initial begin
    logic [7:0] load_bytes [4];
    int         gaps       [4];
    int         first_done;
    load_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    gaps       = '{1, 0, 2, 1};

    // ---- Reset, with a LOAD header presented that must be ignored ----
    rst       = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 8'h43;
    cyc();
    cyc();
    cfg_valid = 1'b0;
    rst       = 1'b0;
    check_reset_outputs("reset");
    cyc();
    check("reset.no_load", 32'(busy), 32'd0);

    // ---- LOAD cell 3 with valid held high ----
    clear_counts();
    cfg_valid = 1'b1;
    cfg_data  = 8'h43;
    cyc();
    check("load.hdr_busy", 32'(busy),   32'd1);
    check("load.hdr_we",   32'(cfg_we), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cfg_data = load_bytes[i];
      cyc();
      check($sformatf("load.we%0d", i),    32'(cfg_we),    32'd1);
      check($sformatf("load.cell%0d", i),  32'(cell_sel),  32'd3);
      check($sformatf("load.addr%0d", i),  32'(cfg_addr),  32'(i));
      check($sformatf("load.wdata%0d", i), 32'(cfg_wdata), 32'(load_bytes[i]));
    end
    cfg_valid = 1'b0;
    check("load.ready_last", 32'(cfg_ready), 32'd1);
    check("load.busy_last",  32'(busy),      32'd1);
    cyc();
    check("load.idle_we",    32'(cfg_we),    32'd0);
    check("load.idle_busy",  32'(busy),      32'd0);
    check("load.hold_wdata", 32'(cfg_wdata), 32'hD4);
    check("load.hold_addr",  32'(cfg_addr),  32'd3);
    check("load.we_count",   32'(we_cnt),    32'd4);

    // ---- RUN with two sweeps ----
    clear_counts();
    cfg_valid = 1'b1;
    cfg_data  = 8'h81;
    cyc();
    cfg_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("run.step%0d", i),  32'(step),      32'd1);
      check($sformatf("run.cell%0d", i),  32'(cell_sel),  32'(i % 8));
      check($sformatf("run.ready%0d", i), 32'(cfg_ready), 32'd0);
      check($sformatf("run.done%0d", i),  32'(done),      32'd0);
      cyc();
    end
    check("run.done",      32'(done),      32'd1);
    check("run.end_step",  32'(step),      32'd0);
    check("run.end_ready", 32'(cfg_ready), 32'd1);
    check("run.end_busy",  32'(busy),      32'd0);
    check("run.hold_cell", 32'(cell_sel),  32'd7);
    cyc();
    check("run.done_pulse", 32'(done),     32'd0);
    check("run.done_count", 32'(done_cnt), 32'd1);
    check("run.no_we",      32'(we_cnt),   32'd0);

    // ---- Illegal header then NOP ----
    clear_counts();
    cfg_valid = 1'b1;
    cfg_data  = 8'hC0;
    cyc();
    check("ill.err",  32'(err),  32'd1);
    check("ill.busy", 32'(busy), 32'd0);
    cfg_data = 8'h00;
    cyc();
    cfg_valid = 1'b0;
    check("nop.err",   32'(err),       32'd1);
    check("nop.busy",  32'(busy),      32'd0);
    check("nop.ready", 32'(cfg_ready), 32'd1);
    cyc();
    check("nop.strobes", 32'(step_cnt + we_cnt + done_cnt), 32'd0);
    check("nop.err_sticky", 32'(err), 32'd1);

    // ---- LOAD cell 5 with gaps, last byte followed by a RUN header ----
    clear_counts();
    cfg_valid = 1'b1;
    cfg_data  = 8'h45;
    cyc();
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        cfg_valid = 1'b0;
        cfg_data  = 8'hFF;
        cyc();
        check($sformatf("gap.busy%0d_%0d", i, g), 32'(busy), 32'd1);
      end
      cfg_valid = 1'b1;
      cfg_data  = 8'h10 + 8'(i);
      cyc();
      check($sformatf("gap.we%0d", i),    32'(cfg_we),    32'd1);
      check($sformatf("gap.cell%0d", i),  32'(cell_sel),  32'd5);
      check($sformatf("gap.addr%0d", i),  32'(cfg_addr),  32'(i));
      check($sformatf("gap.wdata%0d", i), 32'(cfg_wdata), 32'h10 + 32'(i));
    end
    check("b2b.ready", 32'(cfg_ready), 32'd1);
    cfg_data = 8'h80;
    cyc();
    cfg_valid = 1'b0;
    check("b2b.first_step", 32'(step),     32'd1);
    check("b2b.first_cell", 32'(cell_sel), 32'd0);
    for (int i = 0; i < 10; i++) cyc();
    check("b2b.we_count",   32'(we_cnt),   32'd4);
    check("b2b.step_count", 32'(step_cnt), 32'd8);
    check("b2b.done_count", 32'(done_cnt), 32'd1);
    check("b2b.no_overlap", 32'(both_cnt), 32'd0);

    // ---- Reset in the middle of a 64-sweep RUN ----
    clear_counts();
    cfg_valid = 1'b1;
    cfg_data  = 8'hBF;
    cyc();
    cfg_valid = 1'b0;
    for (int i = 0; i < 100 && step_cnt < 20; i++) cyc();
    check("mid.reached_20", 32'(step_cnt), 32'd20);
    check("mid.cell_at_20", 32'(cell_sel), 32'd3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset_outputs("mid");
    for (int i = 0; i < 4; i++) cyc();
    check("mid.no_done",  32'(done_cnt), 32'd0);
    check("mid.no_steps", 32'(step_cnt), 32'd20);
    clear_counts();
    cfg_valid = 1'b1;
    cfg_data  = 8'h80;
    cyc();
    cfg_valid = 1'b0;
    for (int i = 0; i < 12; i++) cyc();
    check("mid.rerun_steps", 32'(step_cnt), 32'd8);
    check("mid.rerun_done",  32'(done_cnt), 32'd1);

    // ---- Maximum sweep count ----
    clear_counts();
    first_done = -1;
    cfg_valid = 1'b1;
    cfg_data  = 8'hBF;
    cyc();
    cfg_valid = 1'b0;
    for (int i = 1; i <= 600; i++) begin
      if (done && first_done < 0) first_done = i;
      cyc();
    end
    check("max.step_count", 32'(step_cnt),   32'd512);
    check("max.done_count", 32'(done_cnt),   32'd1);
    check("max.done_cycle", 32'(first_done), 32'd513);
    check("max.idle_ready", 32'(cfg_ready),  32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fpna_cfg_scheduler.md
FPNA_CFG_SCHEDULER -- requirements
Module: fpna_cfg_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NCELLS, 8, neuron cells in the array; power of two, 2..16.
- CFG_BYTES, 4, configuration bytes per cell; power of two, 1..8.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- cfg_data, in, 8, command/config byte stream.
- cfg_valid, in, 1, cfg_data valid.
- cfg_ready, out, 1, block accepts cfg_data this cycle.
- cell_sel, out, log2(NCELLS), target cell for cfg_we or step.
- cfg_addr, out, log2(CFG_BYTES) (min 1), byte index within the cell.
- cfg_wdata, out, 8, byte to write.
- cfg_we, out, 1, one-cycle config write strobe.
- step, out, 1, one-cycle neuron update strobe for cell_sel.
- busy, out, 1, LOAD or RUN in progress.
- done, out, 1, one-cycle pulse at the end of a RUN.
- err, out, 1, sticky illegal-command flag.

Function
REQ-003 Transfer: a byte is accepted only on a rising edge where cfg_valid=1 and cfg_ready=1; cfg_data is ignored otherwise.
REQ-004 States: IDLE, LOAD, RUN. IDLE and LOAD drive cfg_ready=1; RUN drives cfg_ready=0.
REQ-005 In IDLE, an accepted byte is a header h, decoded on h[7:6].
REQ-006 h[7:6]=00 (NOP): no output activity; remain in IDLE.
REQ-007 h[7:6]=01 (LOAD): latch cell = h[log2(NCELLS)-1:0] and byte index = 0; go to LOAD; other header bits ignored.
REQ-008 h[7:6]=10 (RUN): latch sweeps = h[5:0]+1 (range 1..64); go to RUN.
REQ-009 h[7:6]=11: set err; remain in IDLE; err stays set until rst.
REQ-010 In LOAD, each accepted byte produces, on the following cycle, cfg_we=1, cfg_wdata=that byte, cell_sel=latched cell, cfg_addr=current byte index; the index then increments.
REQ-011 After the CFG_BYTES-th accepted data byte, the block returns to IDLE. The last cfg_we still issues on the next cycle. A header is accepted in that same cycle (back-to-back).
REQ-012 Gaps in cfg_valid during LOAD do not abort it. A partially loaded cell waits indefinitely in LOAD.
REQ-013 RUN timing:
- The first step asserts the cycle after the RUN header is accepted.
- Each sweep drives step=1 for NCELLS consecutive cycles with cell_sel = 0,1,...,NCELLS-1.
- Sweeps run back to back with no idle cycle between them.
- RUN lasts exactly sweeps*NCELLS cycles.
REQ-014 On the cycle after the last step, done=1 for one cycle, the state is IDLE, and cfg_ready=1.
REQ-015 cfg_we and step are never asserted together. Outside their strobe cycles, cfg_we, step and done are 0.
REQ-016 busy=1 while in LOAD, in RUN, or during the trailing cfg_we cycle; busy=0 otherwise.
REQ-017 cell_sel, cfg_addr and cfg_wdata hold their last driven value when no strobe is active.
REQ-018 All counters are sized exactly to their range and wrap only as described; no overflow is possible.

Reset
REQ-019 rst=1 at a rising edge forces IDLE, and clears counters, latched cell and sweeps.
REQ-020 Output values one cycle after that edge: cfg_ready=1; cfg_we=0, step=0, done=0, busy=0, err=0; cell_sel=0, cfg_addr=0, cfg_wdata=0.
REQ-021 Reset mid-LOAD or mid-RUN aborts the operation immediately. The reset cycle produces no strobe, and done is not pulsed.
REQ-022 rst has priority over any simultaneous transfer; a byte presented during reset is not accepted.

Verification
REQ-023 Bench scenarios:
- LOAD: stream 0x43,0xA1,0xB2,0xC3,0xD4 with valid held high -> four cfg_we pulses on consecutive cycles; cell_sel=3; addr 0..3; wdata A1,B2,C3,D4; IDLE after the last.
- RUN: send 0x81 -> 16 consecutive step cycles, cell_sel 0..7 twice; done one cycle later; cfg_ready=0 throughout the 16 cycles.
- Illegal header and NOP: 0xC0 -> err=1 with no strobes; a following 0x00 -> no activity; err stays 1.
- Back-to-back and gaps: LOAD with random valid gaps, last data byte immediately followed by 0x80 -> all 4 writes correct, then 8 steps; no cycle with cfg_we and step both 1.
- Reset mid-RUN: 0xBF, then rst at step 20 -> no done; outputs at reset values; a new 0x80 gives exactly 8 steps.
- Max sweeps: 0xBF -> exactly 512 steps (NCELLS=8); done once.
